router_switch_allocator: RTL and testbench

Per-router switch allocator for the 2D mesh/torus network. Each cycle it decides which input-port FIFO head is forwarded to each of the router's output ports. It arbitrates round-robin among inputs contending for the same output and honours hold requests from the downstream router or node. It also issues FIFO pop strobes, the combinational crossbar select, and a registered write request per output.

---
 rtl/router_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 53 +++++
 rtl/router_switch_allocator.sv | 101 ++++++++++
 tb/tb_router_switch_allocator.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions.
// Holds the port count, the port-index type and the named port indices
// used by the switch allocator and the blocks around it.
package router_pkg;

  localparam int unsigned N_PORTS = 5;
  localparam int unsigned PORT_W  = 3;

  typedef logic [PORT_W-1:0] portIndex_t;

  localparam portIndex_t NORTH = 3'd0;
  localparam portIndex_t EAST  = 3'd1;
  localparam portIndex_t SOUTH = 3'd2;
  localparam portIndex_t WEST  = 3'd3;
  localparam portIndex_t LOCAL = 3'd4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with its own priority pointer.
// Scans requesters starting at the pointer and grants the first one found.
// After a grant the pointer moves to the requester just after the winner.
// Ports:
//   clk_i    clock
//   reset_i  synchronous active-high reset, clears the pointer
//   en_i     0 = grant nothing this cycle and keep the pointer
//   req_i    request vector, one bit per requester
//   grant_o  one-hot or zero grant, combinational
module rr_arbiter #(
  parameter  int unsigned N     = 5,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    logic        found;
    int unsigned idx;
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      // Priority order is ptr, ptr+1, ... with modulo-N wrap.
      idx = 32'(ptr_q) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (en_i && !reset_i && !found && req_i[idx[PTR_W-1:0]]) begin
        found                     = 1'b1;
        grant_o[idx[PTR_W-1:0]]   = 1'b1;
        ptr_d                     = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/router_switch_allocator.sv
// Per-router switch allocator.
// Decodes input-FIFO head requests into a per-output request matrix, runs one
// round-robin arbiter per output, and produces the crossbar selects, the FIFO
// pop strobes, a registered write request per output and a sticky flag for
// requests naming a port that does not exist.
// Ports:
//   clk              clock
//   reset            synchronous active-high reset
//   reqValid[i]      input FIFO i has a head flit
//   reqPort[i]       output port requested by the head of input i
//   downstreamHold[o] receiver on output o cannot accept this cycle
//   grantSel[o][i]   combinational crossbar select, one-hot or zero per output
//   inputPop[i]      combinational FIFO read strobe
//   outWriteRequest[o] registered, output register o holds a valid flit
//   illegalPort      sticky, a valid request named a port >= N_PORTS
module router_switch_allocator #(
  parameter int unsigned N_PORTS = router_pkg::N_PORTS,
  parameter int unsigned PORT_W  = router_pkg::PORT_W
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_PORTS-1:0]                reqValid,
  input  logic [N_PORTS-1:0][PORT_W-1:0]    reqPort,
  input  logic [N_PORTS-1:0]                downstreamHold,
  output logic [N_PORTS-1:0][N_PORTS-1:0]   grantSel,
  output logic [N_PORTS-1:0]                inputPop,
  output logic [N_PORTS-1:0]                outWriteRequest,
  output logic                              illegalPort
);

  localparam logic [PORT_W:0] PORT_LIMIT = N_PORTS[PORT_W:0];

  logic [N_PORTS-1:0][N_PORTS-1:0] req;          // [output][input]
  logic [N_PORTS-1:0]              illegal_hit;
  logic [N_PORTS-1:0]              owr_q;
  logic [N_PORTS-1:0]              owr_d;
  logic                            illegal_q;
  logic                            illegal_d;

  // Out-of-range port numbers never reach an arbiter, so they are neither
  // granted nor popped; they only raise the sticky flag.
  always_comb begin
    req         = '0;
    illegal_hit = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (reqValid[i]) begin
        if ({1'b0, reqPort[i]} >= PORT_LIMIT) begin
          illegal_hit[i] = 1'b1;
        end else if (!reset) begin
          for (int unsigned o = 0; o < N_PORTS; o++) begin
            if (reqPort[i] == o[PORT_W-1:0]) begin
              req[o][i] = 1'b1;
            end
          end
        end
      end
    end
  end

  for (genvar o = 0; o < N_PORTS; o++) begin : g_arb
    rr_arbiter #(
      .N (N_PORTS)
    ) u_arb (
      .clk_i   (clk),
      .reset_i (reset),
      .en_i    (!downstreamHold[o]),
      .req_i   (req[o]),
      .grant_o (grantSel[o])
    );
  end

  // Each input names a single output, so at most one grant can land on it.
  always_comb begin
    inputPop = '0;
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      inputPop = inputPop | grantSel[o];
    end
  end

  always_comb begin
    owr_d = '0;
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      owr_d[o] = |grantSel[o];
    end
    illegal_d = illegal_q | (|illegal_hit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owr_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      owr_q     <= owr_d;
      illegal_q <= illegal_d;
    end
  end

  assign outWriteRequest = owr_q;
  assign illegalPort     = illegal_q;

endmodule

// File: tb/tb_router_switch_allocator.sv
module tb_router_switch_allocator;
  import router_pkg::*;

  typedef struct {
    logic                 rst;
    logic [4:0]           valid;
    logic [4:0][2:0]      port;
    logic [4:0]           hold;
    logic [4:0][4:0]      gsel;
    logic [4:0]           pop;
    logic [4:0]           owr;
    logic                 ill;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [4:0]           reqValid;
  logic [4:0][2:0]      reqPort;
  logic [4:0]           downstreamHold;
  logic [4:0][4:0]      grantSel;
  logic [4:0]           inputPop;
  logic [4:0]           outWriteRequest;
  logic                 illegalPort;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  router_switch_allocator #(
    .N_PORTS (N_PORTS),
    .PORT_W  (PORT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .reqValid        (reqValid),
    .reqPort         (reqPort),
    .downstreamHold  (downstreamHold),
    .grantSel        (grantSel),
    .inputPop        (inputPop),
    .outWriteRequest (outWriteRequest),
    .illegalPort     (illegalPort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // port is {p4,p3,p2,p1,p0}; g is {out4,out3,out2,out1,out0}, each 5-bit input mask
  task automatic add(input logic r, input logic [4:0] v, input logic [14:0] p,
                     input logic [4:0] h, input logic [24:0] g, input logic [4:0] pop,
                     input logic [4:0] owr, input logic ill);
    vec_t t;
    t.rst = r; t.valid = v; t.port = p; t.hold = h;
    t.gsel = g; t.pop = pop; t.owr = owr; t.ill = ill;
    vecs.push_back(t);
  endtask

  // Drive just after a rising edge, check at the falling edge, then let the edge happen.
  task automatic run_vec(input vec_t v, input string nm);
    reset          = v.rst;
    reqValid       = v.valid;
    reqPort        = v.port;
    downstreamHold = v.hold;
    @(negedge clk);
    chk({nm, " grantSel"}, 25'(grantSel), 25'(v.gsel));
    chk({nm, " inputPop"}, 25'(inputPop), 25'(v.pop));
    chk({nm, " outWriteRequest"}, 25'(outWriteRequest), 25'(v.owr));
    chk({nm, " illegalPort"}, 25'(illegalPort), 25'(v.ill));
    @(posedge clk);
    #1;
  endtask

  localparam logic [14:0] P_RR = {3'd0, 3'd4, 3'd0, 3'd4, 3'd4};
  localparam logic [14:0] P_DJ = {3'd4, 3'd1, 3'd0, 3'd3, 3'd2};
  localparam logic [14:0] P_H  = {3'd0, 3'd1, 3'd1, 3'd0, 3'd0};

  initial begin
    vec_t h;
    reset = 1'b1; reqValid = '0; reqPort = '0; downstreamHold = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    add(0, 5'b00000, 15'd0, 5'b0, 25'd0, 5'b0, 5'b0, 0);
    // inputs 0,1,3 -> output 4, round robin 0,1,3,0,1,3
    add(0, 5'b01011, P_RR, 5'b0, {5'b00001, 20'd0}, 5'b00001, 5'b00000, 0);
    add(0, 5'b01011, P_RR, 5'b0, {5'b00010, 20'd0}, 5'b00010, 5'b10000, 0);
    add(0, 5'b01011, P_RR, 5'b0, {5'b01000, 20'd0}, 5'b01000, 5'b10000, 0);
    add(0, 5'b01011, P_RR, 5'b0, {5'b00001, 20'd0}, 5'b00001, 5'b10000, 0);
    add(0, 5'b01011, P_RR, 5'b0, {5'b00010, 20'd0}, 5'b00010, 5'b10000, 0);
    add(0, 5'b01011, P_RR, 5'b0, {5'b01000, 20'd0}, 5'b01000, 5'b10000, 0);
    // disjoint permutation, all five granted
    add(0, 5'b11111, P_DJ, 5'b0, {5'b10000, 5'b00010, 5'b00001, 5'b01000, 5'b00100},
        5'b11111, 5'b10000, 0);
    add(0, 5'b00000, 15'd0, 5'b0, 25'd0, 5'b0, 5'b11111, 0);
    // reset with requests present: nothing granted or popped
    add(1, 5'b11111, P_DJ, 5'b0, 25'd0, 5'b0, 5'b00000, 0);
    // inputs 2,3 -> output 1 under hold for 3 cycles
    add(0, 5'b01100, P_H, 5'b00010, 25'd0, 5'b0, 5'b0, 0);
    add(0, 5'b01100, P_H, 5'b00010, 25'd0, 5'b0, 5'b0, 0);
    add(0, 5'b01100, P_H, 5'b00010, 25'd0, 5'b0, 5'b0, 0);
    add(0, 5'b01100, P_H, 5'b00000, {15'd0, 5'b00100, 5'd0}, 5'b00100, 5'b00000, 0);
    add(0, 5'b01100, P_H, 5'b00000, {15'd0, 5'b01000, 5'd0}, 5'b01000, 5'b00010, 0);
    add(0, 5'b01100, P_H, 5'b00000, {15'd0, 5'b00100, 5'd0}, 5'b00100, 5'b00010, 0);
    // illegal port 6 on input 4: never popped, flag sticky
    add(0, 5'b10000, {3'd6, 12'd0}, 5'b0, 25'd0, 5'b0, 5'b00010, 0);
    add(0, 5'b00000, 15'd0, 5'b0, 25'd0, 5'b0, 5'b00000, 1);
    // U-turn 0 -> 0
    add(0, 5'b00001, 15'd0, 5'b0, {20'd0, 5'b00001}, 5'b00001, 5'b00000, 1);
    add(0, 5'b00000, 15'd0, 5'b0, 25'd0, 5'b0, 5'b00001, 1);
    add(1, 5'b00000, 15'd0, 5'b0, 25'd0, 5'b0, 5'b00000, 1);
    add(0, 5'b00000, 15'd0, 5'b0, 25'd0, 5'b0, 5'b00000, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      run_vec(vecs[k], $sformatf("vec%0d", k));
    end

    // Reset in the cycle input 0 would win output 2; pointer must return to 0.
    h.hold = '0; h.ill = 1'b0;
    h.rst = 0; h.valid = 5'b01000; h.port = {3'd0, 3'd2, 3'd0, 3'd0, 3'd0};
    h.gsel = {10'd0, 5'b01000, 10'd0}; h.pop = 5'b01000; h.owr = 5'b00000;
    run_vec(h, "rst_mid a");
    h.rst = 1; h.valid = 5'b00011; h.port = {3'd0, 3'd0, 3'd0, 3'd2, 3'd2};
    h.gsel = '0; h.pop = 5'b00000; h.owr = 5'b00100;
    run_vec(h, "rst_mid b");
    h.rst = 0; h.valid = 5'b10010; h.port = {3'd2, 3'd0, 3'd0, 3'd2, 3'd0};
    h.gsel = {10'd0, 5'b00010, 10'd0}; h.pop = 5'b00010; h.owr = 5'b00000;
    run_vec(h, "rst_mid c");
    h.rst = 0; h.valid = 5'b00000; h.port = '0;
    h.gsel = '0; h.pop = 5'b00000; h.owr = 5'b00100;
    run_vec(h, "rst_mid d");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
